pdm_cic_decim_mc: RTL and testbench

PDM_CIC_DECIM_MC -- requirements
Module: pdm_cic_decim_mc

---
 rtl/pdm_cic_decim_mc.sv | 134 +++++++++++++
 tb/tb_pdm_cic_decim_mc.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_cic_decim_mc.sv
// Multi-channel PDM to PCM decimator: 3-stage CIC per channel
// with a framed valid/ready output stream and a sticky overrun flag.
module pdm_cic_decim_mc #(
    parameter int NUM_CH = 2,
    parameter int DEC    = 64,
    parameter int OUT_W  = 16,
    localparam int LD    = $clog2(DEC),
    localparam int W     = 3 * LD + 2,
    localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              pdm_tick,
    input  logic [NUM_CH-1:0] pdm_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [CW-1:0]     out_ch,
    output logic              out_last,
    output logic              overrun,
    input  logic              overrun_clr
);

    localparam int SH = W - OUT_W;

    logic [LD-1:0]    cnt;
    logic             dec_pend;
    logic             acc;

    logic [W-1:0]     i1 [NUM_CH];
    logic [W-1:0]     i2 [NUM_CH];
    logic [W-1:0]     i3 [NUM_CH];
    logic [W-1:0]     d1 [NUM_CH];
    logic [W-1:0]     d2 [NUM_CH];
    logic [W-1:0]     d3 [NUM_CH];
    logic [W-1:0]     c1 [NUM_CH];
    logic [W-1:0]     c2 [NUM_CH];
    logic [W-1:0]     c3 [NUM_CH];
    logic signed [W-1:0] shv [NUM_CH];
    logic [OUT_W-1:0] nxt_word [NUM_CH];
    logic [OUT_W-1:0] fbuf [NUM_CH];

    logic             valid_q;
    logic [CW-1:0]    ch_q;
    logic             ovr_q;
    logic             hs;
    logic             last;
    logic             free;
    logic             load;
    logic             drop;

    assign acc = en & pdm_tick;

    // Combs run only in the cycle after the decimation tick.
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            c1[ch]       = i3[ch] - d1[ch];
            c2[ch]       = c1[ch] - d2[ch];
            c3[ch]       = c2[ch] - d3[ch];
            shv[ch]      = $signed(c3[ch]) >>> SH;
            nxt_word[ch] = shv[ch][OUT_W-1:0];
        end
    end

    always_comb begin
        hs   = valid_q & out_ready;
        last = valid_q & (ch_q == CW'(NUM_CH - 1));
        free = ~valid_q | (hs & last);
        load = dec_pend & free;
        drop = dec_pend & ~free;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            dec_pend <= 1'b0;
            valid_q  <= 1'b0;
            ch_q     <= '0;
            ovr_q    <= 1'b0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                i1[ch]   <= '0;
                i2[ch]   <= '0;
                i3[ch]   <= '0;
                d1[ch]   <= '0;
                d2[ch]   <= '0;
                d3[ch]   <= '0;
                fbuf[ch] <= '0;
            end
        end else begin
            dec_pend <= acc & (cnt == LD'(DEC - 1));
            if (acc) begin
                cnt <= cnt + LD'(1);
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    i1[ch] <= i1[ch] + (pdm_in[ch] ? W'(1) : {W{1'b1}});
                    i2[ch] <= i2[ch] + i1[ch];
                    i3[ch] <= i3[ch] + i2[ch];
                end
            end
            // Delay lines advance even when the frame itself is dropped.
            if (dec_pend) begin
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    d1[ch] <= i3[ch];
                    d2[ch] <= c1[ch];
                    d3[ch] <= c2[ch];
                end
            end
            if (load) begin
                for (int ch = 0; ch < NUM_CH; ch++)
                    fbuf[ch] <= nxt_word[ch];
                valid_q <= 1'b1;
                ch_q    <= '0;
            end else if (hs) begin
                if (last) begin
                    valid_q <= 1'b0;
                    ch_q    <= '0;
                end else begin
                    ch_q <= ch_q + CW'(1);
                end
            end
            if (drop)
                ovr_q <= 1'b1;
            else if (overrun_clr)
                ovr_q <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign out_ch    = ch_q;
    assign out_last  = last;
    assign out_data  = fbuf[ch_q];
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_pdm_cic_decim_mc.sv
// Bench for pdm_cic_decim_mc: convolution-form CIC reference model,
// expected words queued per frame and checked on each handshake.
module tb_pdm_cic_decim_mc;

    localparam int NCH = 2;
    localparam int DEC = 64;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en = 1'b0;
    logic           pdm_tick = 1'b0;
    logic [NCH-1:0] pdm_in = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [15:0]    out_data;
    logic [0:0]     out_ch;
    logic           out_last;
    logic           overrun;
    logic           overrun_clr = 1'b0;

    pdm_cic_decim_mc dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .pdm_tick(pdm_tick),
        .pdm_in(pdm_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_ch(out_ch),
        .out_last(out_last),
        .overrun(overrun),
        .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic [0:0]  ch;
        logic        last;
    } exp_t;

    exp_t        q[$];
    bit          hist [NCH][1024];
    int          ntick;
    int          n_assert = 0;
    int          n_fail = 0;
    int          rx_count;
    logic [15:0] last_rx [NCH];
    logic [15:0] first_rx [NCH];
    logic        hold_prev = 1'b0;
    logic [15:0] prev_data;
    logic [0:0]  prev_ch;
    logic        prev_last;

    // Third integrator value after n ticks: sum x_j * C(n-1-j, 2).
    function automatic longint s_of(int ch, int n);
        longint s = 0;
        longint w;
        for (int j = 0; j < n; j++) begin
            w = longint'(n - 1 - j) * longint'(n - 2 - j) / 2;
            s += hist[ch][j] ? w : -w;
        end
        return s;
    endfunction

    function automatic logic [15:0] exp_word(int ch, int n);
        longint c;
        logic [19:0] m;
        logic signed [19:0] sm;
        c = s_of(ch, n) - 3 * s_of(ch, n - DEC)
          + 3 * s_of(ch, n - 2 * DEC) - s_of(ch, n - 3 * DEC);
        m  = c[19:0];
        sm = signed'(m);
        sm = sm >>> 4;
        return sm[15:0];
    endfunction

    task automatic model_tick(input logic [NCH-1:0] p);
        exp_t e;
        for (int ch = 0; ch < NCH; ch++)
            hist[ch][ntick] = p[ch];
        ntick++;
        if (ntick % DEC == 0) begin
            for (int ch = 0; ch < NCH; ch++) begin
                e.d    = exp_word(ch, ntick);
                e.ch   = 1'(ch);
                e.last = (ch == NCH - 1);
                q.push_back(e);
            end
        end
    endtask

    task automatic drive(input logic e, input logic t,
                         input logic [NCH-1:0] p, input logic r);
        @(posedge clk);
        #1;
        en        = e;
        pdm_tick  = t;
        pdm_in    = p;
        out_ready = r;
        if (e && t)
            model_tick(p);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst         = 1'b1;
        en          = 1'b0;
        pdm_tick    = 1'b0;
        out_ready   = 1'b0;
        overrun_clr = 1'b0;
        q.delete();
        ntick    = 0;
        rx_count = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        repeat (10) drive(1'b1, 1'b0, '0, 1'b1);
        @(negedge clk);
        n_assert++;
        if (q.size() !== 0) begin
            n_fail++;
            $display("FAIL drain: %0d words left, expected 0", q.size());
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && hold_prev) begin
            n_assert++;
            if (out_data !== prev_data || out_ch !== prev_ch ||
                out_last !== prev_last) begin
                n_fail++;
                $display("FAIL hold: got %0d/%0d/%0d, expected %0d/%0d/%0d",
                         out_data, out_ch, out_last,
                         prev_data, prev_ch, prev_last);
            end
        end
        hold_prev = !rst && out_valid && !out_ready;
        prev_data = out_data;
        prev_ch   = out_ch;
        prev_last = out_last;
        if (!rst && out_valid && out_ready) begin
            n_assert++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL word: got ch=%0d data=%0d, expected none",
                         out_ch, out_data);
            end else begin
                e = q.pop_front();
                if (out_data !== e.d || out_ch !== e.ch ||
                    out_last !== e.last) begin
                    n_fail++;
                    $display("FAIL word: got d=%0d ch=%0d last=%0d, expected d=%0d ch=%0d last=%0d",
                             $signed(out_data), out_ch, out_last,
                             $signed(e.d), e.ch, e.last);
                end
            end
            last_rx[out_ch] = out_data;
            if (rx_count < NCH)
                first_rx[out_ch] = out_data;
            rx_count++;
        end
    end

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_assert++;
        if (out_valid !== 1'b0 || out_data !== 16'd0 || out_ch !== 1'b0 ||
            out_last !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: got v=%0d d=%0d ch=%0d l=%0d o=%0d, expected all 0",
                     out_valid, out_data, out_ch, out_last, overrun);
        end
    endtask

    task automatic test_all_ones();
        do_reset();
        repeat (6 * DEC) drive(1'b1, 1'b1, 2'b11, 1'b1);
        drain();
        n_assert++;
        if (last_rx[0] !== 16'd16384 || last_rx[1] !== 16'd16384) begin
            n_fail++;
            $display("FAIL all_ones: got %0d %0d, expected 16384 16384",
                     $signed(last_rx[0]), $signed(last_rx[1]));
        end
    endtask

    task automatic test_split();
        do_reset();
        repeat (5 * DEC) drive(1'b1, 1'b1, 2'b01, 1'b1);
        drain();
        n_assert++;
        if (last_rx[0] !== 16'd16384 || last_rx[1] !== 16'hC000) begin
            n_fail++;
            $display("FAIL split: got %0d %0d, expected 16384 -16384",
                     $signed(last_rx[0]), $signed(last_rx[1]));
        end
    endtask

    task automatic test_alternate();
        do_reset();
        for (int k = 0; k < 4 * DEC; k++) begin
            drive(1'b1, 1'b1, (k % 2 == 0) ? 2'b11 : 2'b00, 1'b1);
            if (k == DEC - 1) begin
                drive(1'b1, 1'b0, '0, 1'b1);
                @(negedge clk);
                n_assert++;
                if (out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL latency_t1: got %0d, expected 0", out_valid);
                end
                drive(1'b1, 1'b0, '0, 1'b1);
                @(negedge clk);
                n_assert++;
                if (out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL latency_t2: got %0d, expected 1", out_valid);
                end
            end
        end
        drain();
        n_assert++;
        if (last_rx[0] !== 16'd0 || last_rx[1] !== 16'd0) begin
            n_fail++;
            $display("FAIL alternate: got %0d %0d, expected 0 0",
                     $signed(last_rx[0]), $signed(last_rx[1]));
        end
    endtask

    task automatic test_overrun();
        logic [15:0] held;
        do_reset();
        repeat (DEC) drive(1'b1, 1'b1, 2'b11, 1'b0);
        repeat (3) drive(1'b1, 1'b0, 2'b11, 1'b0);
        @(negedge clk);
        held = out_data;
        n_assert++;
        if (out_valid !== 1'b1 || q.size() == 0 || out_data !== q[0].d) begin
            n_fail++;
            $display("FAIL ovr_first: got v=%0d d=%0d, expected v=1 d=%0d",
                     out_valid, $signed(out_data),
                     (q.size() > 0) ? $signed(q[0].d) : 0);
        end
        repeat (2 * DEC) drive(1'b1, 1'b1, 2'b11, 1'b0);
        repeat (4) drive(1'b1, 1'b0, 2'b11, 1'b0);
        @(negedge clk);
        n_assert++;
        if (overrun !== 1'b1 || out_data !== held || out_ch !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_set: got o=%0d d=%0d ch=%0d, expected o=1 d=%0d ch=0",
                     overrun, $signed(out_data), out_ch, $signed(held));
        end
        @(posedge clk);
        #1 overrun_clr = 1'b1;
        @(posedge clk);
        #1 overrun_clr = 1'b0;
        @(negedge clk);
        n_assert++;
        if (overrun !== 1'b0 || out_valid !== 1'b1 || out_data !== held) begin
            n_fail++;
            $display("FAIL ovr_clr: got o=%0d v=%0d d=%0d, expected o=0 v=1 d=%0d",
                     overrun, out_valid, $signed(out_data), $signed(held));
        end
        while (q.size() > NCH)
            void'(q.pop_back());
        repeat (DEC) drive(1'b1, 1'b1, 2'b11, 1'b1);
        drain();
        n_assert++;
        if (last_rx[0] !== 16'd16384) begin
            n_fail++;
            $display("FAIL ovr_after: got %0d, expected 16384", $signed(last_rx[0]));
        end
    endtask

    task automatic test_enable_gap();
        do_reset();
        for (int k = 0; k < 2 * DEC; k++)
            drive(1'b1, 1'b1, 2'($urandom), ($urandom_range(0, 3) != 0));
        for (int k = 0; k < 100; k++)
            drive(1'b0, 1'(k), 2'($urandom), ($urandom_range(0, 3) != 0));
        for (int k = 0; k < 3 * DEC; k++)
            drive(1'b1, 1'b1, 2'($urandom), ($urandom_range(0, 3) != 0));
        drain();
        n_assert++;
        if (overrun !== 1'b0 || rx_count !== 5 * NCH) begin
            n_fail++;
            $display("FAIL en_gap: got o=%0d words=%0d, expected o=0 words=%0d",
                     overrun, rx_count, 5 * NCH);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (3 * DEC) drive(1'b1, 1'b1, 2'b11, 1'b0);
        repeat (3) drive(1'b1, 1'b0, 2'b11, 1'b0);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        en       = 1'b1;
        pdm_tick = 1'b1;
        q.delete();
        ntick    = 0;
        rx_count = 0;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        en       = 1'b0;
        pdm_tick = 1'b0;
        @(negedge clk);
        n_assert++;
        if (out_valid !== 1'b0 || overrun !== 1'b0 || out_ch !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: got v=%0d o=%0d ch=%0d, expected 0 0 0",
                     out_valid, overrun, out_ch);
        end
        repeat (4 * DEC) drive(1'b1, 1'b1, 2'b11, 1'b1);
        drain();
        n_assert++;
        if (first_rx[0] !== 16'd2604 || last_rx[0] !== 16'd16384) begin
            n_fail++;
            $display("FAIL rst_transient: got %0d %0d, expected 2604 16384",
                     $signed(first_rx[0]), $signed(last_rx[0]));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_all_ones();
        test_split();
        test_alternate();
        test_overrun();
        test_enable_gap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
